// File: rtl/reg_writeback.sv
// Write-back stage: merges single-cycle ALU results and buffered LU results
// onto the register file's single write port with registered outputs.
module reg_writeback #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 2
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         ALU_VALID,
  output logic                         ALU_READY,
  input  logic [ADDR_WIDTH-1:0]        ALU_ADDR,
  input  logic [DATA_WIDTH-1:0]        ALU_DATA,
  input  logic                         LU_VALID,
  output logic                         LU_READY,
  input  logic [ADDR_WIDTH-1:0]        LU_ADDR,
  input  logic [DATA_WIDTH-1:0]        LU_DATA,
  output logic                         WRITE_ENABLE,
  output logic [ADDR_WIDTH-1:0]        WRITE_ADDRESS,
  output logic [DATA_WIDTH-1:0]        WRITE_DATA,
  output logic [$clog2(DEPTH+1)-1:0]   FIFO_COUNT
);

  localparam int CNT_WIDTH = $clog2(DEPTH + 1);
  localparam int PTR_WIDTH = $clog2(DEPTH);

  // FIFO storage is not reset; occupancy tracking alone decides validity.
  logic [ADDR_WIDTH-1:0] fifo_addr_r [DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_r [DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr_r;
  logic [PTR_WIDTH-1:0]  rd_ptr_r;
  logic [CNT_WIDTH-1:0]  count_r;

  logic                  full_s;
  logic                  enq_s;
  logic                  deq_s;
  logic                  sel_valid_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [DATA_WIDTH-1:0] sel_data_s;
  logic [CNT_WIDTH-1:0]  count_next_s;

  // Ready depends only on the registered count, never on the VALID inputs.
  assign full_s     = (count_r == CNT_WIDTH'(DEPTH));
  assign LU_READY   = !full_s;
  assign ALU_READY  = !full_s;
  assign enq_s      = LU_VALID && !full_s;
  assign FIFO_COUNT = count_r;

  // Write-port arbitration: drain when full, else ALU first, else FIFO head.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_addr_s  = fifo_addr_r[rd_ptr_r];
    sel_data_s  = fifo_data_r[rd_ptr_r];
    deq_s       = 1'b0;
    if (full_s) begin
      sel_valid_s = 1'b1;
      deq_s       = 1'b1;
    end else if (ALU_VALID) begin
      sel_valid_s = 1'b1;
      sel_addr_s  = ALU_ADDR;
      sel_data_s  = ALU_DATA;
    end else if (count_r != {CNT_WIDTH{1'b0}}) begin
      sel_valid_s = 1'b1;
      deq_s       = 1'b1;
    end else begin
      sel_valid_s = 1'b0;
    end
  end

  // Occupancy update; a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_next_s = count_r;
    if (enq_s && !deq_s) begin
      count_next_s = count_r + CNT_WIDTH'(1'b1);
    end else if (!enq_s && deq_s) begin
      count_next_s = count_r - CNT_WIDTH'(1'b1);
    end else begin
      count_next_s = count_r;
    end
  end

  // Pointer and count state; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      wr_ptr_r <= {PTR_WIDTH{1'b0}};
      rd_ptr_r <= {PTR_WIDTH{1'b0}};
      count_r  <= {CNT_WIDTH{1'b0}};
    end else begin
      count_r <= count_next_s;
      if (enq_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_WIDTH'(1'b1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (deq_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_WIDTH'(1'b1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

  // Capture accepted LU results into the slot at the write pointer.
  always_ff @(posedge CLK) begin
    if (enq_s) begin
      fifo_addr_r[wr_ptr_r] <= LU_ADDR;
      fifo_data_r[wr_ptr_r] <= LU_DATA;
    end
  end

  // Registered write port; register 0 is consumed silently, idle holds addr/data.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      WRITE_ENABLE  <= 1'b0;
      WRITE_ADDRESS <= {ADDR_WIDTH{1'b0}};
      WRITE_DATA    <= {DATA_WIDTH{1'b0}};
    end else if (sel_valid_s) begin
      WRITE_ENABLE  <= (sel_addr_s != {ADDR_WIDTH{1'b0}});
      WRITE_ADDRESS <= sel_addr_s;
      WRITE_DATA    <= sel_data_s;
    end else begin
      WRITE_ENABLE  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Directed self-checking bench for reg_writeback.
module tb_reg_writeback;

  logic        CLK;
  logic        RESET;
  logic        ALU_VALID;
  logic        ALU_READY;
  logic [4:0]  ALU_ADDR;
  logic [31:0] ALU_DATA;
  logic        LU_VALID;
  logic        LU_READY;
  logic [4:0]  LU_ADDR;
  logic [31:0] LU_DATA;
  logic        WRITE_ENABLE;
  logic [4:0]  WRITE_ADDRESS;
  logic [31:0] WRITE_DATA;
  logic [1:0]  FIFO_COUNT;

  int checks   = 0;
  int failures = 0;

  reg_writeback #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(2)) dut (
    .CLK(CLK), .RESET(RESET),
    .ALU_VALID(ALU_VALID), .ALU_READY(ALU_READY), .ALU_ADDR(ALU_ADDR), .ALU_DATA(ALU_DATA),
    .LU_VALID(LU_VALID), .LU_READY(LU_READY), .LU_ADDR(LU_ADDR), .LU_DATA(LU_DATA),
    .WRITE_ENABLE(WRITE_ENABLE), .WRITE_ADDRESS(WRITE_ADDRESS), .WRITE_DATA(WRITE_DATA),
    .FIFO_COUNT(FIFO_COUNT)
  );

  // Free-running clock, rising edge active.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
    ALU_VALID = av; ALU_ADDR = aa; ALU_DATA = ad;
    LU_VALID  = lv; LU_ADDR  = la; LU_DATA  = ld;
  endtask

  task automatic expect_wr(input string tag, input logic we, input logic [4:0] wa,
                           input logic [31:0] wd, input logic [1:0] cnt);
    chk({tag, "_we"},  {63'd0, WRITE_ENABLE}, {63'd0, we});
    chk({tag, "_wa"},  {59'd0, WRITE_ADDRESS}, {59'd0, wa});
    chk({tag, "_wd"},  {32'd0, WRITE_DATA}, {32'd0, wd});
    chk({tag, "_cnt"}, {62'd0, FIFO_COUNT}, {62'd0, cnt});
  endtask

  task automatic expect_rdy(input string tag, input logic rdy);
    chk({tag, "_alu_rdy"}, {63'd0, ALU_READY}, {63'd0, rdy});
    chk({tag, "_lu_rdy"},  {63'd0, LU_READY},  {63'd0, rdy});
  endtask

  initial begin
    // 1. Reset with VALIDs high
    RESET = 1'b0;
    drive(1'b1, 5'd9, 32'h1111_1111, 1'b1, 5'd8, 32'h2222_2222);
    tick();
    tick();
    expect_wr("reset", 1'b0, 5'd0, 32'h0, 2'd0);
    expect_rdy("reset", 1'b1);
    RESET = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    expect_wr("post_reset_idle", 1'b0, 5'd0, 32'h0, 2'd0);

    // 2. ALU only
    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0);
    expect_rdy("alu_pre", 1'b1);
    tick();
    expect_wr("alu_wr", 1'b1, 5'd5, 32'hDEAD_BEEF, 2'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    expect_wr("alu_idle_hold", 1'b0, 5'd5, 32'hDEAD_BEEF, 2'd0);

    // 3. LU only: count 1 in N+1, write in N+2
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h1234_5678);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    expect_wr("lu_n1", 1'b0, 5'd5, 32'hDEAD_BEEF, 2'd1);
    tick();
    expect_wr("lu_n2", 1'b1, 5'd7, 32'h1234_5678, 2'd0);
    tick();
    expect_wr("lu_n3", 1'b0, 5'd7, 32'h1234_5678, 2'd0);

    // 4. Contention: ALU every cycle, LU pushes 1,2,3
    drive(1'b1, 5'd10, 32'hA000_0010, 1'b1, 5'd1, 32'hB000_0001);
    expect_rdy("ct0", 1'b1);
    tick();
    expect_wr("ct0", 1'b1, 5'd10, 32'hA000_0010, 2'd1);
    drive(1'b1, 5'd11, 32'hA000_0011, 1'b1, 5'd2, 32'hB000_0002);
    expect_rdy("ct1", 1'b1);
    tick();
    expect_wr("ct1", 1'b1, 5'd11, 32'hA000_0011, 2'd2);
    drive(1'b1, 5'd12, 32'hA000_0012, 1'b1, 5'd3, 32'hB000_0003);
    expect_rdy("ct2_full", 1'b0);
    tick();
    expect_wr("ct2", 1'b1, 5'd1, 32'hB000_0001, 2'd1);
    expect_rdy("ct3", 1'b1);
    tick();
    expect_wr("ct3", 1'b1, 5'd12, 32'hA000_0012, 2'd2);
    drive(1'b1, 5'd13, 32'hA000_0013, 1'b0, 5'd0, 32'h0);
    expect_rdy("ct4_full", 1'b0);
    tick();
    expect_wr("ct4", 1'b1, 5'd2, 32'hB000_0002, 2'd1);
    expect_rdy("ct5", 1'b1);
    tick();
    expect_wr("ct5", 1'b1, 5'd13, 32'hA000_0013, 2'd1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    expect_wr("ct6", 1'b1, 5'd3, 32'hB000_0003, 2'd0);

    // 5. Address 0 results are consumed without a write
    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0);
    expect_rdy("a0_alu", 1'b1);
    tick();
    chk("a0_alu_we", {63'd0, WRITE_ENABLE}, 64'd0);
    chk("a0_alu_cnt", {62'd0, FIFO_COUNT}, 64'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h5555_5555);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("a0_lu_enq_we", {63'd0, WRITE_ENABLE}, 64'd0);
    chk("a0_lu_enq_cnt", {62'd0, FIFO_COUNT}, 64'd1);
    tick();
    chk("a0_lu_deq_we", {63'd0, WRITE_ENABLE}, 64'd0);
    chk("a0_lu_deq_cnt", {62'd0, FIFO_COUNT}, 64'd0);

    // 6. Reset with a full FIFO discards buffered entries
    drive(1'b1, 5'd30, 32'hD000_0030, 1'b1, 5'd20, 32'hC000_0020);
    tick();
    expect_wr("mr0", 1'b1, 5'd30, 32'hD000_0030, 2'd1);
    drive(1'b1, 5'd31, 32'hD000_0031, 1'b1, 5'd21, 32'hC000_0021);
    tick();
    expect_wr("mr1", 1'b1, 5'd31, 32'hD000_0031, 2'd2);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    RESET = 1'b0;
    tick();
    RESET = 1'b1;
    expect_wr("mr_reset", 1'b0, 5'd0, 32'h0, 2'd0);
    expect_rdy("mr_reset", 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_wr("mr_after", 1'b0, 5'd0, 32'h0, 2'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
